// File: rtl/adder_check_pkg.sv
// Shared types, widths and golden model for the carry-select adder sweep checker.
package adder_check_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned VEC_W = 2 * WIDTH + 1;
  localparam int unsigned ERR_W = 2 * WIDTH + 2;
  localparam int unsigned N_VEC = 1 << VEC_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full-width reference sum {cout, s}; never truncated.
  function automatic logic [WIDTH:0] expected_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             cin);
    return (WIDTH + 1)'(a) + (WIDTH + 1)'(b) + (WIDTH + 1)'(cin);
  endfunction

endpackage

// File: rtl/adder_sweep_checker_if.sv
// Control, stimulus and result bundle between the sweep checker and its environment.
interface adder_sweep_checker_if;
  import adder_check_pkg::*;

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] fail_vec;
  logic [WIDTH:0]   fail_resp;

  modport master (
    output start, abort, dut_s, dut_cout,
    input  dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_valid, fail_vec, fail_resp
  );

  modport slave (
    input  start, abort, dut_s, dut_cout,
    output dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_valid, fail_vec, fail_resp
  );
endinterface

// File: rtl/adder_vector_gen.sv
// Sweep index counter; b is the innermost field, then a, then cin.
module adder_vector_gen
  import adder_check_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic             last_c
);

  logic [VEC_W-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       v <= '0;
    else if (clear)   v <= '0;
    else if (advance) v <= v + VEC_W'(1);
  end

  assign b      = v[WIDTH-1:0];
  assign a      = v[2*WIDTH-1:WIDTH];
  assign cin    = v[2*WIDTH];
  assign last_c = &v;

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive sweep of the adder under check with settle delay, error count and first-failure capture.
module adder_sweep_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_sweep_checker_if.slave bus
);

  localparam logic [1:0]       S_IDLE    = IDLE;
  localparam logic [1:0]       S_RUN     = RUN;
  localparam logic [1:0]       S_DONE    = DONE;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             busy, done, pass, fail_valid;
  logic [ERR_W-1:0] err_count, err_next_c;
  logic [VEC_W-1:0] fail_vec;
  logic [WIDTH:0]   fail_resp;

  logic [WIDTH-1:0] vec_a, vec_b;
  logic             vec_cin, last_c;
  logic             clr_c, adv_c, dec_c, cmp_c, finish_c, leave_c, mismatch_c;

  adder_vector_gen u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clr_c),
    .advance (adv_c),
    .a       (vec_a),
    .b       (vec_b),
    .cin     (vec_cin),
    .last_c  (last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle control strobes; abort outranks compare in RUN.
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    adv_c      = 1'b0;
    dec_c      = 1'b0;
    cmp_c      = 1'b0;
    finish_c   = 1'b0;
    leave_c    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          clr_c      = 1'b1;
          state_next = S_RUN;
        end else if (bus.abort && state == S_DONE) begin
          leave_c    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          leave_c    = 1'b1;
          state_next = S_IDLE;
        end else if (settle_cnt != '0) begin
          dec_c = 1'b1;
        end else begin
          cmp_c = 1'b1;
          if (last_c) begin
            finish_c   = 1'b1;
            state_next = S_DONE;
          end else begin
            adv_c = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mismatch_c = cmp_c && ({bus.dut_cout, bus.dut_s} != expected_sum(vec_a, vec_b, vec_cin));
  assign err_next_c = err_count + ERR_W'(mismatch_c);

  // Settle counter, status flags and failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_resp  <= '0;
    end else if (clr_c) begin
      settle_cnt <= SETTLE_LD;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_resp  <= '0;
    end else begin
      if (adv_c)      settle_cnt <= SETTLE_LD;
      else if (dec_c) settle_cnt <= settle_cnt - CNT_W'(1);
      if (mismatch_c) begin
        err_count <= err_next_c;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= {vec_cin, vec_a, vec_b};
          fail_resp  <= {bus.dut_cout, bus.dut_s};
        end
      end
      if (leave_c) begin
        busy <= 1'b0;
        done <= 1'b0;
        pass <= 1'b0;
      end else if (finish_c) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next_c == '0);
      end
    end
  end

  assign bus.dut_a      = vec_a;
  assign bus.dut_b      = vec_b;
  assign bus.dut_cin    = vec_cin;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;
  assign bus.fail_resp  = fail_resp;

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Self-checking response end for the 4-bit carry-select adder. The block drives the adder's operand inputs through every combination of A, B and C_in, samples S/C_out after a settle window, and compares them against a golden sum. It accumulates an error count, captures the first failing vector, and reports pass/fail through a start/done handshake. It sits beside the adder in on-chip or FPGA bring-up builds and in regression benches as the hardware counterpart of the stimulus sweep.

## Interface
- WIDTH, 4, operand width of the adder under check
- SETTLE_CYCLES, 1, extra cycles each vector is held before its response is sampled (0..15)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; sampled in IDLE or DONE only
- abort  in  1  synchronous abandon of a running sweep
- dut_a  out  WIDTH  operand A to the adder, registered
- dut_b  out  WIDTH  operand B to the adder, registered
- dut_cin  out  1  carry-in to the adder, registered
- dut_s  in  WIDTH  adder sum response
- dut_cout  in  1  adder carry-out response
- busy  out  1  sweep in progress
- done  out  1  sweep finished; sticky until next start or abort
- pass  out  1  done and err_count == 0
- err_count  out  2*WIDTH+2  number of mismatching vectors
- fail_valid  out  1  first failure captured
- fail_vec  out  2*WIDTH+1  {cin, a, b} of first failure
- fail_resp  out  WIDTH+1  {cout, s} observed at first failure

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: dut_a/dut_b/dut_cin = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_valid = 0, fail_vec = 0, fail_resp = 0.
- Vector index v has 2*WIDTH+1 bits: b = v[WIDTH-1:0], a = v[2*WIDTH-1:WIDTH], cin = v[2*WIDTH]. b is the innermost loop, then a, then cin. Total N = 2^(2*WIDTH+1) vectors (512 at WIDTH = 4).
- IDLE/DONE, start = 1:
  - clear err_count, fail_*, done and pass
  - load v = 0 onto the dut_* outputs
  - load settle counter = SETTLE_CYCLES
  - busy = 1, go to RUN
- RUN, settle counter != 0: decrement the counter.
- RUN, settle counter == 0: compare.
  - Expected {cout, s} = a + b + cin, computed at WIDTH+1 bits with no truncation.
  - On mismatch: err_count += 1. If fail_valid == 0, capture fail_vec, capture fail_resp, and set fail_valid.
  - If v is all-ones: go to DONE with busy = 0, done = 1, and pass = (final err_count == 0). The final vector's own comparison is included.
  - Otherwise: v += 1, drive the new vector, reload the settle counter.
- v never wraps. The all-ones index terminates the sweep.
- err_count cannot overflow: N < 2^(2*WIDTH+2).
- start while in RUN is ignored.
- abort in RUN returns to IDLE with busy = 0 and done = 0. err_count and fail_* hold their partial values. abort has priority over the compare in the same cycle.
- abort in IDLE or DONE has no effect, except that in DONE it clears done/pass and moves to IDLE.
- start and abort together in IDLE/DONE: start wins.
- rst_n low at any time, including mid-sweep: all outputs go to their reset values immediately.

## Timing
- start sampled at edge k: vector 0 appears after edge k, and busy rises after edge k.
- Each vector is held for SETTLE_CYCLES+1 cycles. It is compared at edge k + (i+1)*(SETTLE_CYCLES+1) for vector i.
- done rises after edge k + N*(SETTLE_CYCLES+1). With defaults this is 1024 cycles after the start edge.
- dut_s/dut_cout must be stable at least one full cycle before the compare edge. The DUT is combinational, and SETTLE_CYCLES = 0 is legal for it.
- The err_count and fail_* updates for a vector are visible the cycle after its compare edge.

## Structure
- Package adder_check_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparams derived from WIDTH: VEC_W = 2*WIDTH+1, ERR_W = 2*WIDTH+2, N_VEC
  - function expected_sum(a, b, cin) returning WIDTH+1 bits
- Sub-module adder_vector_gen:
  - the VEC_W-bit index counter with clear/advance inputs
  - outputs a, b, cin and a last flag
- The top level holds the FSM, settle counter, comparator and capture registers.

## Test plan
- Golden 4-bit CSA attached, defaults, start pulse → done after 1024 cycles, err_count = 0, pass = 1, fail_valid = 0.
- DUT with S[0] stuck at 0 → err_count = 256, fail_vec = {0, 0000, 0001}, fail_resp = 5'b00000, pass = 0.
- DUT with C_out stuck at 0 → err_count = 256 (120 with cin = 0, 136 with cin = 1), fail_vec = {0, 0001, 1111}, fail_resp = 5'b00000.
- Golden DUT with SETTLE_CYCLES = 3 → done exactly 2048 cycles after the start edge. Each vector is held for 4 cycles, checked by monitoring dut_a/dut_b.
- abort at cycle 300, then start again → after abort: busy = 0, done = 0. After the restart: full sweep, err_count = 0, pass = 1. Start pulses inside RUN are ignored (the completion cycle is unchanged).
- rst_n asserted at cycle 500 of a sweep → all outputs are reset values in the same cycle. After release and a new start, the sweep completes normally.
